// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern engine: pattern modes, bounce
// direction, the step-rate increment table and the speed-select priority decode.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_ALT    = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int unsigned N_SPEEDS = 7;

  // Accumulator increment per speed_sel bit, bit 0 first.
  localparam logic [6:0] INC_TABLE [N_SPEEDS] = '{7'd1, 7'd2, 7'd5, 7'd10, 7'd20, 7'd50, 7'd100};

  // Lowest set bit of sel picks the increment; no bit set keeps cur.
  function automatic logic [6:0] speed_to_inc(input logic [6:0] sel, input logic [6:0] cur);
    logic [6:0] r;
    logic       hit;
    r   = cur;
    hit = 1'b0;
    for (int unsigned i = 0; i < N_SPEEDS; i++) begin
      if (sel[i] && !hit) begin
        r   = INC_TABLE[i];
        hit = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/led_pattern_engine_rate.sv
// Fractional rate accumulator: decodes speed_sel into an increment and
// raises step when the accumulator has reached CLK_HZ and is allowed to wrap.
module rate_accumulator
  import led_pattern_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned ACC_W  = $clog2(CLK_HZ + 101)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] speed_sel,
  input  logic       clear,
  input  logic       pause,
  output logic       step
);

  localparam logic [ACC_W-1:0] THRESH = ACC_W'(CLK_HZ);

  logic [6:0]       inc;
  logic [ACC_W-1:0] acc;
  logic             due;

  // A due step waits in acc until neither pause nor a mode reload blocks it.
  assign due  = (acc >= THRESH);
  assign step = due & ~pause & ~clear;

  // Increment register tracks speed_sel even while paused; acc wraps, holds or accumulates.
  always_ff @(posedge clk) begin
    if (reset) begin
      inc <= 7'd1;
      acc <= '0;
    end else begin
      inc <= speed_to_inc(speed_sel, inc);
      if (clear) begin
        acc <= '0;
      end else if (!pause) begin
        acc <= due ? '0 : acc + ACC_W'(inc);
      end
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern generator: four selectable patterns advanced by the rate
// accumulator, with a registered one-cycle step pulse for other display logic.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int unsigned N_LEDS = 10,
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned ACC_W  = $clog2(CLK_HZ + 101)
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [6:0]        speed_sel,
  input  logic [1:0]        mode,
  input  logic              pause,
  output logic [N_LEDS-1:0] LEDR,
  output logic              step
);

  mode_t             mode_q;
  mode_t             mode_in;
  logic              mode_chg;
  logic              adv;
  dir_t              dir;
  dir_t              dir_next;
  logic [N_LEDS-1:0] pat_next;
  logic [N_LEDS-1:0] pat_init;

  assign mode_in  = mode_t'(mode);
  assign mode_chg = (mode_in != mode_q);

  rate_accumulator #(
    .CLK_HZ(CLK_HZ),
    .ACC_W (ACC_W)
  ) u_rate (
    .clk      (CLOCK_50),
    .reset    (reset),
    .speed_sel(speed_sel),
    .clear    (mode_chg),
    .pause    (pause),
    .step     (adv)
  );

  function automatic logic [N_LEDS-1:0] init_pattern(input mode_t m);
    logic [N_LEDS-1:0] p;
    p = '0;
    case (m)
      MODE_ALT: begin
        for (int unsigned i = 0; i < N_LEDS; i++) p[i] = 1'(i % 2);
      end
      MODE_CHASE, MODE_BOUNCE: p[0] = 1'b1;
      default: p = '0;
    endcase
    return p;
  endfunction

  // Reload value for the requested mode.
  always_comb begin
    pat_init = init_pattern(mode_in);
  end

  // Next pattern position and bounce direction for one advance.
  always_comb begin
    pat_next = LEDR;
    dir_next = dir;
    case (mode_q)
      MODE_ALT:   pat_next = ~LEDR;
      MODE_CHASE: pat_next = {LEDR[N_LEDS-2:0], LEDR[N_LEDS-1]};
      MODE_BOUNCE: begin
        // Turning at an end also moves one position, so there is no dwell.
        if (dir == DIR_UP) begin
          if (LEDR[N_LEDS-1]) begin
            pat_next = LEDR >> 1;
            dir_next = DIR_DOWN;
          end else begin
            pat_next = LEDR << 1;
          end
        end else begin
          if (LEDR[0]) begin
            pat_next = LEDR << 1;
            dir_next = DIR_UP;
          end else begin
            pat_next = LEDR >> 1;
          end
        end
      end
      default: pat_next = LEDR + 1'b1;
    endcase
  end

  // Pattern state: reset beats mode reload, reload beats an advance.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      mode_q <= MODE_ALT;
      LEDR   <= init_pattern(MODE_ALT);
      dir    <= DIR_UP;
      step   <= 1'b0;
    end else if (mode_chg) begin
      mode_q <= mode_in;
      LEDR   <= pat_init;
      dir    <= DIR_UP;
      step   <= 1'b0;
    end else if (adv) begin
      LEDR   <= pat_next;
      dir    <= dir_next;
      step   <= 1'b1;
    end else begin
      step   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine: a 10-LED and a 4-LED instance share stimulus;
// a step-count reference model predicts LEDR and step every cycle.
module tb_led_pattern_engine;

  localparam int CLK = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] speed_sel;
  logic [1:0] mode;
  logic       pause;
  logic [9:0] led10;
  logic [3:0] led4;
  logic       step10;
  logic       step4;

  int checks = 0;
  int errors = 0;

  // Reference state: pattern is derived from steps taken since the last reload.
  int m_acc, m_inc, m_mode, m_k, m_step;
  int inc_tab [7] = '{1, 2, 5, 10, 20, 50, 100};

  always #5 clk = ~clk;

  led_pattern_engine #(.N_LEDS(10), .CLK_HZ(CLK)) dut10 (
    .CLOCK_50(clk), .reset(reset), .speed_sel(speed_sel), .mode(mode),
    .pause(pause), .LEDR(led10), .step(step10)
  );

  led_pattern_engine #(.N_LEDS(4), .CLK_HZ(CLK)) dut4 (
    .CLOCK_50(clk), .reset(reset), .speed_sel(speed_sel), .mode(mode),
    .pause(pause), .LEDR(led4), .step(step4)
  );

  function automatic logic [31:0] exp_led(input int n, input int m, input int k);
    int base, mask, p, idx;
    base = 0;
    for (int i = 1; i < n; i += 2) base |= (1 << i);
    mask = (1 << n) - 1;
    case (m)
      0: return (k % 2 == 1) ? 32'(~base & mask) : 32'(base);
      1: return 32'(1 << (k % n));
      2: begin
        p   = k % (2 * n - 2);
        idx = (p < n) ? p : (2 * n - 2 - p);
        return 32'(1 << idx);
      end
      default: return 32'(k % (1 << n));
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int new_inc;
    if (reset) begin
      m_acc = 0; m_inc = 1; m_mode = 0; m_k = 0; m_step = 0;
    end else begin
      new_inc = m_inc;
      for (int i = 6; i >= 0; i--) if (speed_sel[i]) new_inc = inc_tab[i];
      if (int'(mode) != m_mode) begin
        m_mode = int'(mode); m_k = 0; m_acc = 0; m_step = 0;
      end else if (pause) begin
        m_step = 0;
      end else if (m_acc >= CLK) begin
        m_acc = 0; m_k++; m_step = 1;
      end else begin
        m_acc += m_inc; m_step = 0;
      end
      m_inc = new_inc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("led10", 32'(led10), exp_led(10, m_mode, m_k));
    chk("led4", 32'(led4), exp_led(4, m_mode, m_k));
    chk("step10", 32'(step10), 32'(m_step));
    chk("step4", 32'(step4), 32'(m_step));
  endtask

  task automatic measure(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!step10 && n < 200);
  endtask

  task automatic wait_due();
    int g;
    g = 0;
    while (m_acc < CLK && g < 500) begin
      tick();
      g++;
    end
    chk("wait_due_bound", 32'(g < 500), 32'd1);
  endtask

  int n;
  int bounce_idx [7] = '{1, 2, 3, 2, 1, 0, 1};

  initial begin
    reset = 1'b1; speed_sel = '0; mode = 2'd0; pause = 1'b0;
    m_acc = 0; m_inc = 1; m_mode = 0; m_k = 0; m_step = 0;
    #2;
    repeat (3) tick();
    chk("reset_led10", 32'(led10), 32'h2AA);
    chk("reset_led4", 32'(led4), 32'hA);
    chk("reset_step", 32'(step10), 32'd0);

    // Default rate: inc 1 gives a 21-cycle period.
    reset = 1'b0;
    measure(n);
    chk("first_step_latency", 32'(n), 32'd21);
    chk("first_step_led", 32'(led10), 32'h155);
    measure(n);
    chk("period_inc1", 32'(n), 32'd21);

    speed_sel = 7'b0000100;
    measure(n); measure(n);
    chk("period_inc5", 32'(n), 32'd5);
    speed_sel = 7'b0000110;
    measure(n); measure(n);
    chk("period_inc2", 32'(n), 32'd11);
    speed_sel = 7'b0000000;
    measure(n); measure(n);
    chk("period_hold", 32'(n), 32'd11);

    // Chase with wrap at inc 100.
    speed_sel = 7'b1000000;
    mode = 2'd1;
    tick();
    chk("chase_init", 32'(led10), 32'd1);
    measure(n);
    for (int j = 2; j <= 11; j++) begin
      measure(n);
      chk("chase_period", 32'(n), 32'd2);
      chk("chase_led", 32'(led10), 32'(1 << (j % 10)));
    end

    // Bounce on the 4-LED instance.
    mode = 2'd2;
    tick();
    chk("bounce_init", 32'(led4), 32'd1);
    for (int j = 0; j < 7; j++) begin
      measure(n);
      chk("bounce_seq", 32'(led4), 32'(1 << bounce_idx[j]));
    end

    // Count through wrap, then a mode switch on a step-due edge.
    mode = 2'd3;
    tick();
    chk("count_init", 32'(led4), 32'd0);
    for (int j = 1; j <= 16; j++) begin
      measure(n);
      chk("count_led", 32'(led4), 32'(j % 16));
    end
    wait_due();
    mode = 2'd1;
    tick();
    chk("switch_led", 32'(led4), 32'd1);
    chk("switch_nostep", 32'(step4), 32'd0);
    measure(n);
    chk("switch_acc_restart", 32'(n), 32'd2);

    // Pause over a due step: frozen, then step on the first unpaused edge.
    wait_due();
    pause = 1'b1;
    for (int j = 0; j < 50; j++) begin
      tick();
      chk("pause_nostep", 32'(step10), 32'd0);
    end
    pause = 1'b0;
    tick();
    chk("pause_release_step", 32'(step10), 32'd1);

    // Randomised phase.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 19) == 0)
        speed_sel = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'(1 << $urandom_range(2, 6));
      else if ($urandom_range(0, 29) == 0)
        speed_sel = '0;
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom);
      pause = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0; pause = 1'b0;

    // Reset in the middle of a run.
    speed_sel = 7'b1000000;
    mode = 2'd2;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    chk("midrun_reset_led10", 32'(led10), 32'h2AA);
    chk("midrun_reset_led4", 32'(led4), 32'hA);
    chk("midrun_reset_step", 32'(step10), 32'd0);
    reset = 1'b0;
    mode = 2'd0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
# led_pattern_engine

Parametrised LED pattern generator for the board LED bank, driven directly from `CLOCK_50`. A priority-encoded switch bank selects the step rate through a fractional rate accumulator. A 2-bit mode input selects one of four patterns: alternate, chase, bounce, binary count. It sits at top level between the switch inputs and `LEDR`, and exports a step pulse for other display logic.

## Interface
- `N_LEDS`, 10, LED count; must be ≥ 2.
- `CLK_HZ`, 50_000_000, accumulator threshold (one step per second at increment 1).
- `ACC_W`, $clog2(CLK_HZ+101), accumulator width; the accumulator never exceeds CLK_HZ+99.
- `CLOCK_50`  in  1  system clock; only clock.
- `reset`  in  1  synchronous, active-high reset.
- `speed_sel`  in  7  rate request; lowest set bit wins.
- `mode`  in  2  pattern select: 0 alternate, 1 chase, 2 bounce, 3 count.
- `pause`  in  1  freeze accumulator and pattern while high.
- `LEDR`  out  N_LEDS  current pattern (registered).
- `step`  out  1  one-cycle pulse on each pattern advance (registered).

## Operation
- Increment table, indexed by speed_sel bit 0..6: 1, 2, 5, 10, 20, 50, 100.
- The increment register takes the entry of the lowest set bit. If speed_sel = 0, the increment holds its last value.
- Accumulator rule, each cycle:
  - if acc ≥ CLK_HZ: acc ← 0 and a step occurs;
  - else: acc ← acc + inc (using the inc value registered before this edge).
- Step period in cycles = ceil(CLK_HZ/inc) + 1.
- A speed change does not clear acc. It takes effect one cycle later.
- Patterns advance one position per step:
  - alternate: even LEDs = phase, odd LEDs = ~phase; phase toggles.
  - chase: one-hot rotate toward higher index; LED[N-1] wraps to LED[0].
  - bounce: one-hot; direction up flips to down on reaching LED[N-1], down flips to up on reaching LED[0]. No dwell at the ends: sequence 0,1,…,N-1,N-2,…,0,1.
  - count: LEDR = binary count + 1, wrapping mod 2^N_LEDS.
- Initial pattern per mode:
  - alternate: odd bits 1, even bits 0.
  - chase: LED[0] only.
  - bounce: LED[0] only, direction up.
  - count: 0.
- `mode` is compared against a registered copy `mode_q`. On mismatch: load the new mode's initial pattern, clear acc, no step, mode_q ← mode.
- Priority per cycle: reset > mode change > pause > step.
- `pause`: acc, inc-driven stepping and pattern all hold. inc may still update. step = 0.

## Timing
- Reset values:
  - LEDR = alternate initial pattern (odd bits 1).
  - step 0, acc 0, inc 1, mode_q 0, bounce direction up.
- If `mode` ≠ 0 during reset, the mode-change reload occurs on the first edge after reset deasserts.
- Step latency: on the edge where acc ≥ CLK_HZ is sampled, LEDR updates and step = 1, both in the same cycle. step is high for exactly one cycle.
- Reset mid-step overrides: that cycle produces no step, and the pattern returns to its reset value.
- Mode change coincident with a step: the reload wins and the step is dropped.
- Pause asserted on a step-due cycle: the step is deferred until pause falls. acc stays ≥ CLK_HZ, so the step fires on the first unpaused edge.

## Structure
- Package `led_pattern_pkg` holds:
  - mode constants MODE_ALT/MODE_CHASE/MODE_BOUNCE/MODE_COUNT;
  - the 7-entry increment table;
  - the speed-select priority function.
- Sub-module `rate_accumulator` owns speed_sel decode, the inc register, acc, and pause gating. Its ports are clear and pause in, step out.
- `led_pattern_engine` owns mode_q, the pattern register and the bounce direction.

## Test plan
- CLK_HZ=20, N_LEDS=10, speed_sel=0, mode=0, release reset:
  - LEDR=10'b1010101010;
  - first step after 21 cycles, giving 10'b0101010101;
  - step period 21 cycles.
- speed_sel=7'b0000100 (inc 5): period 5 cycles. Then speed_sel=7'b0000110: bit 1 wins, inc 2, period 11. Then speed_sel=0: period stays 11.
- mode=1, inc 100: LEDR 1,2,4,…,512,1 on successive steps (wrap checked), step period 2 cycles.
- mode=2, N_LEDS=4, inc 100: LED index sequence 0,1,2,3,2,1,0,1.
- mode=3, N_LEDS=4: count 0..15 then 0. Switch mode to 1 on a step-due cycle: LEDR=4'b0001, no step pulse, acc restarts from 0.
- pause held 50 cycles while a step is due: LEDR and acc frozen. Release: step on the first edge. Assert reset mid-run: next cycle shows the reset values.
